vga_sync_gen: RTL and testbench

- Raster timing generator for the TinyQV VGA peripheral.
- Sits directly upstream of the VRAM/pixel stage. Supplies beam position, sync pulses, blank and a per-line retrace strobe.
- Raises a sticky frame interrupt that the CPU clears.
- Default timing is 1024x768@60 (65 MHz nominal), run from the 64 MHz project clock.

---
 rtl/vga_sync_gen.sv | 107 ++++++++++
 tb/tb_vga_sync_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator for the TinyQV VGA peripheral.
// Free-running x/y beam counters with registered sync, blank, retrace and a
// sticky frame interrupt. Every output register decodes the next (x,y), so
// all outputs line up with the x/y presented in the same cycle.
//
// Optional feature macro: VGA_SYNC_LINE_IRQ_EN
//   When defined, adds irq_line/irq_line_en so the interrupt can also fire at
//   the start of hblank on a chosen line.
//
// Totals must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024 (11/10-bit counters).
module vga_sync_gen #(
  parameter int H_VISIBLE = 1024,
  parameter int H_FRONT   = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BACK    = 160,
  parameter int V_VISIBLE = 768,
  parameter int V_FRONT   = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 29,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
`ifdef VGA_SYNC_LINE_IRQ_EN
  input  logic [9:0]  irq_line,
  input  logic [0:0]  irq_line_en,
`endif
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        retrace,
  output logic        blank,
  output logic        interrupt
);

  // Timing boundaries sized to the counter widths so every compare is exact.
  localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
  localparam logic [10:0] H_SS    = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SE    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] H_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0]  V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SS    = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SE    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic        HS_ACT  = 1'(HSYNC_POL);
  localparam logic        VS_ACT  = 1'(VSYNC_POL);

  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;
  logic        h_act_nxt;
  logic        v_act_nxt;
  logic        blank_nxt;
  logic        retrace_nxt;
  logic        irq_set;
  logic        line_hit;

  // Next beam position: x wraps at end of line, y advances (and wraps) with it.
  always_comb begin
    x_nxt = x + 11'd1;
    y_nxt = y;
    if (x == H_LAST) begin
      x_nxt = 11'd0;
      if (y == V_LAST) y_nxt = 10'd0;
      else             y_nxt = y + 10'd1;
    end
  end

  // Decode of the next position; registered below alongside x/y.
  always_comb begin
    blank_nxt   = (x_nxt >= H_VIS) || (y_nxt >= V_VIS);
    h_act_nxt   = (x_nxt >= H_SS) && (x_nxt < H_SE);
    v_act_nxt   = (y_nxt >= V_SS) && (y_nxt < V_SE);
    retrace_nxt = (x_nxt == H_VIS) && (y_nxt < V_VIS);
`ifdef VGA_SYNC_LINE_IRQ_EN
    // irq_line beyond the last line never equals y_nxt, so it never fires.
    line_hit    = irq_line_en[0] && (x_nxt == H_VIS) && (y_nxt == irq_line);
`else
    line_hit    = 1'b0;
`endif
    irq_set     = ((x_nxt == 11'd0) && (y_nxt == V_VIS)) || line_hit;
  end

  // Counters and registered outputs; a set request outranks cli.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x         <= 11'd0;
      y         <= 10'd0;
      hsync     <= ~HS_ACT;
      vsync     <= ~VS_ACT;
      blank     <= 1'b0;
      retrace   <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      x         <= x_nxt;
      y         <= y_nxt;
      hsync     <= h_act_nxt ? HS_ACT : ~HS_ACT;
      vsync     <= v_act_nxt ? VS_ACT : ~VS_ACT;
      blank     <= blank_nxt;
      retrace   <= retrace_nxt;
      interrupt <= irq_set | (interrupt & ~cli);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen using a reduced raster
// (25 clocks x 17 lines) so whole frames fit in a short run.
//   H: visible 16, front 2, sync 4 (x=18..21), back 3  -> H_TOTAL 25
//   V: visible 10, front 2, sync 3 (y=12..14), back 2  -> V_TOTAL 17
//   Frame = 425 clocks; frame interrupt at (0,10) = 250 clocks after reset.
module tb_vga_sync_gen;

  logic        clk;
  logic        rst_n;
  logic        cli;
  logic [10:0] x;
  logic [9:0]  y;
  logic        hsync;
  logic        vsync;
  logic        retrace;
  logic        blank;
  logic        interrupt;
`ifdef VGA_SYNC_LINE_IRQ_EN
  logic [9:0]  irq_line;
  logic [0:0]  irq_line_en;
`endif

  int errors = 0;
  int checks = 0;

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(3), .V_BACK(2),
    .HSYNC_POL(0),  .VSYNC_POL(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cli(cli),
`ifdef VGA_SYNC_LINE_IRQ_EN
    .irq_line(irq_line),
    .irq_line_en(irq_line_en),
`endif
    .x(x),
    .y(y),
    .hsync(hsync),
    .vsync(vsync),
    .retrace(retrace),
    .blank(blank),
    .interrupt(interrupt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; sample point is 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-clock synchronous reset; afterwards the DUT sits at (0,0).
  task automatic do_reset();
    rst_n = 1'b0;
    cli   = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (x !== 11'd0)      begin errors++; $display("FAIL reset_x got=%0d exp=0", x); end
    checks++; if (y !== 10'd0)      begin errors++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (hsync !== 1'b1)   begin errors++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
    checks++; if (vsync !== 1'b1)   begin errors++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
    checks++; if (blank !== 1'b0)   begin errors++; $display("FAIL reset_blank got=%b exp=0", blank); end
    checks++; if (retrace !== 1'b0) begin errors++; $display("FAIL reset_retrace got=%b exp=0", retrace); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", interrupt); end
  endtask

  task automatic test_line_wrap();
    do_reset();
    step(25);
    checks++; if (x !== 11'd0) begin errors++; $display("FAIL wrap_x got=%0d exp=0", x); end
    checks++; if (y !== 10'd1) begin errors++; $display("FAIL wrap_y got=%0d exp=1", y); end
  endtask

  task automatic test_line_decode();
    int hs_low;
    int rt_cnt;
    logic exp_blank;
    logic exp_hsync;
    logic exp_rt;
    hs_low = 0;
    rt_cnt = 0;
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      int xe;
      step(1);
      xe = k % 25;
      exp_blank = (xe >= 16);
      exp_hsync = !((xe >= 18) && (xe <= 21));
      exp_rt    = (xe == 16);
      if (!hsync) hs_low++;
      if (retrace) rt_cnt++;
      checks++; if (x !== 11'(xe)) begin errors++; $display("FAIL line_x got=%0d exp=%0d", x, xe); end
      checks++; if (blank !== exp_blank) begin errors++; $display("FAIL line_blank x=%0d got=%b exp=%b", xe, blank, exp_blank); end
      checks++; if (hsync !== exp_hsync) begin errors++; $display("FAIL line_hsync x=%0d got=%b exp=%b", xe, hsync, exp_hsync); end
      checks++; if (retrace !== exp_rt) begin errors++; $display("FAIL line_retrace x=%0d got=%b exp=%b", xe, retrace, exp_rt); end
    end
    checks++; if (hs_low != 4) begin errors++; $display("FAIL line_hsync_width got=%0d exp=4", hs_low); end
    checks++; if (rt_cnt != 1) begin errors++; $display("FAIL line_retrace_count got=%0d exp=1", rt_cnt); end
  endtask

  task automatic test_frame();
    int rt_cnt;
    int vs_low;
    int vs_bad;
    int hs_vbl;
    int first_vx;
    int first_vy;
    rt_cnt = 0;
    vs_low = 0;
    vs_bad = 0;
    hs_vbl = 0;
    first_vx = -1;
    first_vy = -1;
    do_reset();
    for (int k = 1; k <= 425; k++) begin
      step(1);
      if (retrace) rt_cnt++;
      if (!vsync) begin
        vs_low++;
        if (first_vx < 0) begin first_vx = int'(x); first_vy = int'(y); end
        if (y < 10'd12 || y > 10'd14) vs_bad++;
      end
      if (!hsync && y >= 10'd10) hs_vbl++;
      if (k == 249) begin
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL frame_irq_early got=%b exp=0", interrupt); end
      end
      if (k == 250) begin
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL frame_irq_set got=%b exp=1", interrupt); end
        checks++; if (x !== 11'd0 || y !== 10'd10) begin errors++; $display("FAIL frame_irq_pos got=(%0d,%0d) exp=(0,10)", x, y); end
      end
    end
    checks++; if (rt_cnt != 10) begin errors++; $display("FAIL frame_retrace_count got=%0d exp=10", rt_cnt); end
    checks++; if (vs_low != 75) begin errors++; $display("FAIL frame_vsync_clocks got=%0d exp=75", vs_low); end
    checks++; if (vs_bad != 0) begin errors++; $display("FAIL frame_vsync_range got=%0d exp=0", vs_bad); end
    checks++; if (first_vx != 0 || first_vy != 12) begin errors++; $display("FAIL frame_vsync_start got=(%0d,%0d) exp=(0,12)", first_vx, first_vy); end
    checks++; if (hs_vbl != 28) begin errors++; $display("FAIL frame_hsync_vblank got=%0d exp=28", hs_vbl); end
    checks++; if (x !== 11'd0 || y !== 10'd0) begin errors++; $display("FAIL frame_wrap got=(%0d,%0d) exp=(0,0)", x, y); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL frame_irq_sticky got=%b exp=1", interrupt); end
  endtask

  task automatic test_interrupt_cli();
    do_reset();
    step(253);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL cli_hold got=%b exp=1", interrupt); end
    cli = 1'b1;
    step(1);
    cli = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL cli_clear got=%b exp=0", interrupt); end
    cli = 1'b1;
    step(1);
    cli = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL cli_idle got=%b exp=0", interrupt); end
    // cli coinciding with the set edge: set wins.
    do_reset();
    step(249);
    cli = 1'b1;
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL cli_set_wins got=%b exp=1", interrupt); end
    step(1);
    cli = 1'b0;
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL cli_after_set got=%b exp=0", interrupt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    // (20,13): hsync and vsync both active, blank, interrupt pending.
    step(425 + 13 * 25 + 20);
    checks++; if (x !== 11'd20 || y !== 10'd13) begin errors++; $display("FAIL mid_pos got=(%0d,%0d) exp=(20,13)", x, y); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0 || blank !== 1'b1 || interrupt !== 1'b1) begin
      errors++; $display("FAIL mid_outputs got hs=%b vs=%b bl=%b irq=%b exp 0 0 1 1", hsync, vsync, blank, interrupt);
    end
    do_reset();
    checks++; if (x !== 11'd0 || y !== 10'd0) begin errors++; $display("FAIL mid_reset_pos got=(%0d,%0d) exp=(0,0)", x, y); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || blank !== 1'b0 || interrupt !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs got hs=%b vs=%b bl=%b irq=%b exp 1 1 0 0", hsync, vsync, blank, interrupt);
    end
    step(1);
    checks++; if (x !== 11'd1 || y !== 10'd0) begin errors++; $display("FAIL mid_restart got=(%0d,%0d) exp=(1,0)", x, y); end
  endtask

`ifdef VGA_SYNC_LINE_IRQ_EN
  task automatic test_line_irq();
    irq_line    = 10'd4;
    irq_line_en = 1'b1;
    do_reset();
    step(115);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL lirq_early got=%b exp=0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1 || x !== 11'd16 || y !== 10'd4) begin
      errors++; $display("FAIL lirq_set got irq=%b at (%0d,%0d) exp 1 at (16,4)", interrupt, x, y);
    end
    irq_line_en = 1'b0;
    do_reset();
    step(249);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL lirq_disabled got=%b exp=0", interrupt); end
    step(1);
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL lirq_frame got=%b exp=1", interrupt); end
    irq_line    = 10'd20;
    irq_line_en = 1'b1;
    do_reset();
    step(249);
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL lirq_out_of_range got=%b exp=0", interrupt); end
    irq_line_en = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    cli   = 1'b0;
`ifdef VGA_SYNC_LINE_IRQ_EN
    irq_line    = 10'd0;
    irq_line_en = 1'b0;
`endif
    step(2);
    test_reset();
    test_line_wrap();
    test_line_decode();
    test_frame();
    test_interrupt_cli();
    test_mid_reset();
`ifdef VGA_SYNC_LINE_IRQ_EN
    test_line_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
